outer1bits_fill: RTL

//  Inverse of outer1bits: takes the one-hot leftmost/rightmost set-bit positions and rebuilds the

---
 rtl/outer1bits_pkg.sv | 35 +++
 rtl/onehot2therm.sv | 39 +++
 rtl/outer1bits_fill.sv | 113 +++++++++++
 3 files changed

// File: rtl/outer1bits_pkg.sv
// Shared types and helpers for the outer1bits fill path: one-hot checks and index conversion.
package outer1bits_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    // Helpers take a wide vector so any WIDTH up to MAX_W can reuse them via a cast.
    localparam int unsigned MAX_W     = 32;

    typedef struct packed {
        logic [WIDTH_DEF-1:0]         therm_l;
        logic [WIDTH_DEF-1:0]         therm_r;
        logic [$clog2(WIDTH_DEF)-1:0] idx_l;
        logic [$clog2(WIDTH_DEF)-1:0] idx_r;
        logic                         zero_both;
        logic                         bad;
    } fill_s1_t;

    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic int unsigned onehot2idx(input logic [MAX_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_W; i++) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot2therm.sv
// Combinational one-hot to thermometer code, bit index and one-hot flag.
module onehot2therm
    import outer1bits_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    // DIR=0: therm[i]=1 for i<=pos (MSB-side bound); DIR=1: therm[i]=1 for i>=pos (LSB-side bound)
    parameter bit          DIR   = 1'b0
) (
    input  logic [WIDTH-1:0]         oh_i,
    output logic [WIDTH-1:0]         therm_o,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     onehot_o
);

    localparam int unsigned IW = $clog2(WIDTH);

    logic [WIDTH-1:0] fill;
    logic             acc;

    always_comb begin
        fill = '0;
        acc  = 1'b0;
        if (!DIR) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                acc     = acc | oh_i[i];
                fill[i] = acc;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                acc     = acc | oh_i[i];
                fill[i] = acc;
            end
        end
        onehot_o = is_onehot(MAX_W'(oh_i));
        idx_o    = IW'(onehot2idx(MAX_W'(oh_i)));
        therm_o  = onehot_o ? fill : '0;
    end

endmodule

// File: rtl/outer1bits_fill.sv
// Rebuilds the inclusive fill mask between one-hot left/right positions, plus its popcount.
module outer1bits_fill
    import outer1bits_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       data_val_i,
    input  logic [WIDTH-1:0]           data_left_i,
    input  logic [WIDTH-1:0]           data_right_i,
    output logic                       data_val_o,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(WIDTH+1)-1:0] span_o,
    output logic                       error_o
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned SW = $clog2(WIDTH+1);

    typedef struct packed {
        logic [WIDTH-1:0] therm_l;
        logic [WIDTH-1:0] therm_r;
        logic [IW-1:0]    idx_l;
        logic [IW-1:0]    idx_r;
        logic             zero_both;
        logic             bad;
    } s1_t;

    logic             val_a_q, val_b_q, val_o_q;
    logic [WIDTH-1:0] left_a_d, left_a_q, right_a_d, right_a_q;
    s1_t              s1_d, s1_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [SW-1:0]    span_d, span_q;
    logic             err_d, err_q;

    logic [WIDTH-1:0] therm_l, therm_r;
    logic [IW-1:0]    idx_l, idx_r;
    logic             oh_l, oh_r;

    onehot2therm #(.WIDTH(WIDTH), .DIR(1'b0)) u_therm_l (
        .oh_i     (left_a_q),
        .therm_o  (therm_l),
        .idx_o    (idx_l),
        .onehot_o (oh_l)
    );

    onehot2therm #(.WIDTH(WIDTH), .DIR(1'b1)) u_therm_r (
        .oh_i     (right_a_q),
        .therm_o  (therm_r),
        .idx_o    (idx_r),
        .onehot_o (oh_r)
    );

    always_comb begin
        left_a_d  = data_val_i ? data_left_i  : left_a_q;
        right_a_d = data_val_i ? data_right_i : right_a_q;

        s1_d = s1_q;
        if (val_a_q) begin
            s1_d.therm_l   = therm_l;
            s1_d.therm_r   = therm_r;
            s1_d.idx_l     = idx_l;
            s1_d.idx_r     = idx_r;
            s1_d.zero_both = (left_a_q == '0) && (right_a_q == '0);
            s1_d.bad       = !s1_d.zero_both && !(oh_l && oh_r && (idx_l >= idx_r));
        end

        data_d = data_q;
        span_d = span_q;
        err_d  = err_q;
        if (val_b_q) begin
            err_d = s1_q.bad;
            if (s1_q.bad || s1_q.zero_both) begin
                data_d = '0;
                span_d = '0;
            end else begin
                data_d = s1_q.therm_l & s1_q.therm_r;
                span_d = SW'(s1_q.idx_l) - SW'(s1_q.idx_r) + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            val_a_q   <= 1'b0;
            val_b_q   <= 1'b0;
            val_o_q   <= 1'b0;
            left_a_q  <= '0;
            right_a_q <= '0;
            s1_q      <= '0;
            data_q    <= '0;
            span_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            val_a_q   <= data_val_i;
            val_b_q   <= val_a_q;
            val_o_q   <= val_b_q;
            left_a_q  <= left_a_d;
            right_a_q <= right_a_d;
            s1_q      <= s1_d;
            data_q    <= data_d;
            span_q    <= span_d;
            err_q     <= err_d;
        end
    end

    assign data_val_o = val_o_q;
    assign data_o     = data_q;
    assign span_o     = span_q;
    assign error_o    = err_q;

endmodule
